// File: rtl/mem_access_router.sv
// Routes CPU burst reads/fill-writes to an internal RAM (low region) or an external bus (high region).
// Internal beats take 1 (write) or 2 (read) cycles; external beats wait on ext_ack, bounded by TIMEOUT.
module mem_access_router #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 20,
  parameter int INT_ADDR_WIDTH = 8,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [1:0]                burst_len,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      int_we,
  output logic [INT_ADDR_WIDTH-1:0] int_addr,
  output logic [DATA_WIDTH-1:0]     int_wdata,
  input  logic [DATA_WIDTH-1:0]     int_rdata,
  output logic                      ext_req,
  output logic                      ext_we,
  output logic [ADDR_WIDTH-1:0]     ext_addr,
  output logic [DATA_WIDTH-1:0]     ext_wdata,
  input  logic                      ext_ack,
  input  logic [DATA_WIDTH-1:0]     ext_rdata
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    INT_ACC,
    INT_WAIT,
    EXT_WAIT,
    EXT_NEXT,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              beats_left;
  logic                    wr_dir;
  logic [TCW-1:0]          tcnt;

  // Burst end address with a carry bit so overflow past the top of the map is visible.
  logic [ADDR_WIDTH:0]     last_addr;
  logic                    start_int;
  logic                    last_int;
  logic                    range_bad;

  assign last_addr = {1'b0, addr} + {{(ADDR_WIDTH-1){1'b0}}, burst_len};
  assign start_int = (addr[ADDR_WIDTH-1:INT_ADDR_WIDTH] == '0);
  assign last_int  = (last_addr[ADDR_WIDTH:INT_ADDR_WIDTH] == '0);
  assign range_bad = last_addr[ADDR_WIDTH] | (start_int != last_int);

  assign int_addr  = cur_addr[INT_ADDR_WIDTH-1:0];
  assign int_wdata = wdata_q;
  assign ext_addr  = cur_addr;
  assign ext_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      wdata_q    <= '0;
      beats_left <= '0;
      wr_dir     <= 1'b0;
      tcnt       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      int_we     <= 1'b0;
      ext_req    <= 1'b0;
      ext_we     <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      int_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (we || re) begin
            err        <= 1'b0;
            wr_dir     <= we;
            wdata_q    <= data_in;
            beats_left <= burst_len;
            cur_addr   <= addr;
            busy       <= 1'b1;
            if ((we && re) || range_bad) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else if (start_int) begin
              int_we <= we;
              state  <= INT_ACC;
            end else begin
              ext_req <= 1'b1;
              ext_we  <= we;
              tcnt    <= '0;
              state   <= EXT_WAIT;
            end
          end
        end

        INT_ACC: begin
          if (!wr_dir) begin
            state <= INT_WAIT;
          end else if (beats_left != 2'd0) begin
            beats_left <= beats_left - 2'd1;
            cur_addr   <= cur_addr + ADDR_WIDTH'(1);
            int_we     <= 1'b1;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        // RAM data for the address driven in INT_ACC is present now.
        INT_WAIT: begin
          data_out   <= int_rdata;
          data_valid <= 1'b1;
          if (beats_left != 2'd0) begin
            beats_left <= beats_left - 2'd1;
            cur_addr   <= cur_addr + ADDR_WIDTH'(1);
            state      <= INT_ACC;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        EXT_WAIT: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            if (!wr_dir) begin
              data_out   <= ext_rdata;
              data_valid <= 1'b1;
            end
            if (beats_left != 2'd0) begin
              beats_left <= beats_left - 2'd1;
              cur_addr   <= cur_addr + ADDR_WIDTH'(1);
              state      <= EXT_NEXT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end

        EXT_NEXT: begin
          ext_req <= 1'b1;
          ext_we  <= wr_dir;
          tcnt    <= '0;
          state   <= EXT_WAIT;
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          ext_req <= 1'b0;
          ext_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_router.sv
// Randomised and directed bench for mem_access_router: RAM and external-bus models plus a
// scoreboard that pairs every read beat and completion pulse with its predicted value.
module tb_mem_access_router;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [19:0] addr;
  logic [7:0]  data_in;
  logic [1:0]  burst_len;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic        int_we;
  logic [7:0]  int_addr;
  logic [7:0]  int_wdata;
  logic [7:0]  int_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [19:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;

  mem_access_router dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .burst_len(burst_len), .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .done(done), .err(err), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_rdata(int_rdata), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int unsigned a);
    return 8'((a * 37) + 11);
  endfunction

  function automatic logic [7:0] ext_default(input int unsigned a);
    return 8'((a * 13) ^ 32'h5A);
  endfunction

  // Environment models: internal RAM with one-cycle read latency, external bus slave.
  logic [7:0] int_ram [256];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) int_ram[i] <= init_val(i);
    end else begin
      if (int_we) int_ram[int_addr] <= int_wdata;
      int_rdata <= int_ram[int_addr];
    end
  end

  typedef struct packed {
    logic [19:0] a;
    logic        w;
    logic [7:0]  d;
  } beat_t;

  logic [7:0]  ext_mem [int unsigned];
  beat_t       ext_log [$];
  bit          ack_en;
  int          ack_delay;
  int          wcnt;
  initial begin
    ext_ack   = 1'b0;
    ext_rdata = 8'h00;
    wcnt      = 0;
  end
  always @(negedge clk) begin
    if (ext_ack) begin
      ext_ack = 1'b0;
    end else if (ext_req && ack_en) begin
      if (wcnt >= ack_delay) begin
        ext_ack   = 1'b1;
        ext_rdata = ext_mem.exists(ext_addr) ? ext_mem[ext_addr] : ext_default(ext_addr);
        if (ext_we) ext_mem[ext_addr] = ext_wdata;
        ext_log.push_back({ext_addr, ext_we, ext_wdata});
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Reference memory image, updated from the request stream alone.
  logic [7:0] ref_int [256];
  logic [7:0] ref_ext [int unsigned];

  function automatic logic [7:0] ref_rd(input int unsigned a);
    if (a < 256) return ref_int[a];
    return ref_ext.exists(a) ? ref_ext[a] : ext_default(a);
  endfunction

  typedef struct packed {
    logic e;
    logic dv;
  } done_t;

  logic [7:0] exp_dat  [$];
  done_t      exp_done [$];

  int n_intwe  = 0;
  int n_extreq = 0;
  always @(negedge clk) begin
    if (int_we)  n_intwe++;
    if (ext_req) n_extreq++;
  end

  // Monitor: scoreboard pops plus bus-protocol checks.
  logic        prev_req = 1'b0;
  logic [19:0] prev_addr = '0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_wdata = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        if (exp_dat.size() == 0) chk("unexpected_data_valid", 32'(data_out), 32'hFFFF_FFFF);
        else chk("read_data", 32'(data_out), 32'(exp_dat.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 32'(err), 32'hFFFF_FFFF);
        else begin
          done_t dd;
          dd = exp_done.pop_front();
          chk("err_at_done", 32'(err), 32'(dd.e));
          if (dd.dv) chk("last_valid_with_done", 32'(data_valid), 32'd1);
        end
      end
      if (int_we || ext_req) chk("int_ext_exclusive", 32'(int_we & ext_req), 32'd0);
      if (ext_req && prev_req)
        chk("ext_stable", {11'd0, ext_addr, ext_we}, {11'd0, prev_addr, prev_we});
      if (ext_req && prev_req && ext_we) chk("ext_wdata_stable", 32'(ext_wdata), 32'(prev_wdata));
    end
    prev_req   = ext_req;
    prev_addr  = ext_addr;
    prev_we    = ext_we;
    prev_wdata = ext_wdata;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Issues one request and predicts its outcome; returns #1 after the accept edge.
  task automatic drive_req(input logic w, input logic r, input logic [19:0] a,
                           input logic [7:0] d, input logic [1:0] bl,
                           input bit push, input bit expect_timeout);
    int unsigned lst;
    bit          bad_req;
    wait_idle();
    lst     = 32'(a) + 32'(bl);
    bad_req = (w && r) || (lst > 32'hFFFFF) || ((a < 256) != (lst < 256));
    if (push) begin
      if (bad_req || expect_timeout) begin
        exp_done.push_back({1'b1, 1'b0});
      end else if (w) begin
        for (int k = 0; k <= int'(bl); k++) begin
          if (lst < 256) ref_int[32'(a) + k] = d;
          else ref_ext[32'(a) + k] = d;
        end
        exp_done.push_back({1'b0, 1'b0});
      end else begin
        for (int k = 0; k <= int'(bl); k++) exp_dat.push_back(ref_rd(32'(a) + k));
        exp_done.push_back({1'b0, 1'b1});
      end
    end
    we = w; re = r; addr = a; data_in = d; burst_len = bl;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    int n;
    int c_int;
    int c_ext;
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; data_in = '0; burst_len = '0;
    ack_en = 1'b1; ack_delay = 0; ram_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_int[i] = init_val(i);
    @(posedge clk);
    #1 ram_init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {24'd0, busy, done, data_valid, err, int_we, ext_req, ext_we, 1'b0}, 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_addr", 32'(ext_addr), 32'd0);
    reset = 1'b0;

    // Single internal write: int_we in the first cycle, done in the second.
    drive_req(1'b1, 1'b0, 20'h00010, 8'h55, 2'd0, 1, 0);
    @(negedge clk);
    chk("iw_int_we", 32'(int_we), 32'd1);
    chk("iw_int_addr", 32'(int_addr), 32'h10);
    chk("iw_int_wdata", 32'(int_wdata), 32'h55);
    chk("iw_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("iw_done_cycle2", 32'(done), 32'd1);
    drive_req(1'b0, 1'b1, 20'h00010, 8'h00, 2'd0, 1, 0);
    wait_done();

    // Four-beat internal read of a known pattern.
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b1, 1'b0, 20'(32'h20 + k), 8'(k + 1), 2'd0, 1, 0);
      wait_done();
    end
    drive_req(1'b0, 1'b1, 20'h00020, 8'h00, 2'd3, 1, 0);
    wait_done();

    // Two-beat external fill.
    ack_delay = 3;
    ext_log.delete();
    drive_req(1'b1, 1'b0, 20'h00100, 8'hAA, 2'd1, 1, 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy && !ext_req) n++;
    end
    chk("ef_gap_cycles", 32'(n), 32'd1);
    chk("ef_beats", 32'(ext_log.size()), 32'd2);
    if (ext_log.size() == 2) begin
      chk("ef_beat0", 32'(ext_log[0]), {3'd0, 20'h00100, 1'b1, 8'hAA});
      chk("ef_beat1", 32'(ext_log[1]), {3'd0, 20'h00101, 1'b1, 8'hAA});
    end
    drive_req(1'b0, 1'b1, 20'h00100, 8'h00, 2'd1, 1, 0);
    wait_done();

    // Burst crossing the region boundary: rejected without any access.
    c_int = n_intwe; c_ext = n_extreq;
    drive_req(1'b0, 1'b1, 20'h000FE, 8'h00, 2'd3, 1, 0);
    wait_done();
    chk("xr_no_int", 32'(n_intwe - c_int), 32'd0);
    chk("xr_no_ext", 32'(n_extreq - c_ext), 32'd0);

    // External read with no ack: timeout.
    ack_en = 1'b0;
    drive_req(1'b0, 1'b1, 20'h00200, 8'h00, 2'd2, 1, 1);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ext_req) n++;
      if (done) break;
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    @(negedge clk);
    chk("to_req_low", 32'(ext_req), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    ack_en = 1'b1;
    drive_req(1'b0, 1'b1, 20'h00030, 8'h00, 2'd0, 1, 0);
    chk("err_clear_at_accept", 32'(err), 32'd0);
    wait_done();

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      logic [19:0] a;
      logic        w;
      logic        r;
      case ($urandom_range(0, 3))
        0: a = 20'($urandom_range(0, 255));
        1: a = 20'(32'h100 + $urandom_range(0, 31));
        2: a = 20'(32'hFFFFC + $urandom_range(0, 3));
        default: a = 20'(32'hFC + $urandom_range(0, 3));
      endcase
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) == 0) ? 1'b1 : ~w;
      ack_delay = $urandom_range(0, 4);
      drive_req(w, r, a, 8'($urandom), 2'($urandom_range(0, 3)), 1, 0);
      wait_done();
    end

    // Reset while an external beat is outstanding.
    ack_en = 1'b0;
    drive_req(1'b0, 1'b1, 20'h00300, 8'h00, 2'd1, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ext_req", 32'(ext_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("rst_mid_no_done", 32'(n), 32'd0);
    ack_en = 1'b1;
    c_int = n_intwe; c_ext = n_extreq;
    drive_req(1'b1, 1'b1, 20'h00040, 8'h11, 2'd0, 1, 0);
    wait_done();
    chk("both_no_int", 32'(n_intwe - c_int), 32'd0);
    chk("both_no_ext", 32'(n_extreq - c_ext), 32'd0);

    repeat (3) @(negedge clk);
    chk("pending_data", 32'(exp_dat.size()), 32'd0);
    chk("pending_done", 32'(exp_done.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
